// File: rtl/ins_encoder.sv
// Encodes field-level instruction descriptors into 32-bit MIPS words and streams
// them into an instruction memory, one word per cycle, within a start/stop session.
module ins_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_code,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Result bit 32 flags a supported code; bits 31:0 hold the instruction word.
  function automatic logic [32:0] encode(input logic [4:0]  c,
                                         input logic [4:0]  s,
                                         input logic [4:0]  t,
                                         input logic [4:0]  d,
                                         input logic [4:0]  sa,
                                         input logic [15:0] im);
    logic [5:0]  fn;
    logic [5:0]  op;
    logic [32:0] res;
    fn  = 6'd0;
    op  = 6'd0;
    res = 33'd0;
    case (c)
      5'd0:    fn = 6'b100000;
      5'd1:    fn = 6'b100001;
      5'd2:    fn = 6'b100010;
      5'd3:    fn = 6'b100011;
      5'd4:    fn = 6'b100100;
      5'd5:    fn = 6'b100101;
      5'd6:    fn = 6'b100111;
      5'd7:    fn = 6'b101010;
      5'd8:    fn = 6'b000000;
      5'd9:    fn = 6'b000010;
      5'd10:   fn = 6'b000011;
      5'd13:   op = 6'b001100;
      5'd14:   op = 6'b001101;
      5'd15:   op = 6'b001010;
      5'd16:   op = 6'b001000;
      5'd17:   op = 6'b001001;
      5'd18:   op = 6'b100011;
      5'd19:   op = 6'b101011;
      5'd20:   op = 6'b001111;
      default: op = 6'd0;
    endcase
    if (c <= 5'd7)
      res = {1'b1, 6'd0, s, t, d, 5'd0, fn};
    else if (c <= 5'd10)
      res = {1'b1, 6'd0, 5'd0, t, d, sa, fn};
    else if (c == 5'd11)
      res = {1'b1, 6'd0, s, 15'd0, 6'b001000};
    else if (c == 5'd12)
      res = {1'b1, 32'd0};
    else if (c <= 5'd19)
      res = {1'b1, op, s, t, im};
    else if (c == 5'd20)
      res = {1'b1, op, 5'd0, t, im};
    else
      res = 33'd0;
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [32:0]       enc;
  logic              accept;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    in_ready = (state_q == LOAD) && (cnt_q != DEPTH);
    enc      = encode(alu_code, rs, rt, rd, shamt, imm);
    accept   = in_valid && in_ready;

    // The accepted word is registered straight into the write port, so the
    // pointer and count advance on the same edge the write becomes visible.
    if (accept) begin
      if (enc[32]) begin
        wen_d   = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc[31:0];
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (start)               state_d = LOAD;
        else if (stop)           state_d = IDLE;
        else if (cnt_d == DEPTH) state_d = FULL;
      end
      FULL: begin
        if (start)     state_d = LOAD;
        else if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      ptr_d = BASE;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_wen   = wen_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule
